alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station that feeds the integer ALU: it is the issuing end of the ALU's rob_id/valid/op/v1/v2 interface.
- Buffers decoded ALU and branch instructions from the issue stage.
- Snoops the ALU and LSB result broadcasts to wake waiting operands.
- Each cycle, dispatches at most one ready entry to the ALU through registered outputs.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2).
- ROB_W, 4, ROB tag width; must equal the ALU's ROB id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  mispredict clear
- issue_valid  in  1  new instruction this cycle
- issue_rob_id  in  ROB_W  destination tag
- issue_op  in  3  funct3
- issue_instr_type  in  7  opcode
- issue_op_other  in  1  funct7[5] (sub/sra)
- issue_vj, issue_vk  in  32 each  operand values
- issue_qj_wait, issue_qk_wait  in  1 each  operand not yet available
- issue_qj, issue_qk  in  ROB_W each  producer tags
- full  out  1  no free entry
- alu_valid  out  1  dispatch strobe to ALU
- alu_rob_id  out  ROB_W
- alu_op  out  3
- alu_instr_type  out  7
- alu_op_other  out  1
- alu_v1, alu_v2  out  32 each
- alu_cdb_ready  in  1  ALU broadcast valid
- alu_cdb_rob_id  in  ROB_W
- alu_cdb_result  in  32
- lsb_cdb_ready  in  1  LSB broadcast valid
- lsb_cdb_rob_id  in  ROB_W
- lsb_cdb_result  in  32

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all entries not busy; alu_valid=0; alu_rob_id, alu_op, alu_instr_type, alu_op_other, alu_v1, alu_v2 all 0; full=0.
- rdy=0: no state changes, outputs hold; rst has priority over rdy.
- flush=1 (with rdy=1): all entries cleared and alu_valid<=0 at the edge. Issue and wakeup that cycle are ignored.
- Per-entry state: busy, rob_id, op, instr_type, op_other, vj, vk, qj, qk, wj, wk (wait flags).
- full is combinational: 1 iff all RS_SIZE entries are busy. An issue while full is an upstream protocol violation; the entry is dropped and no state changes.
- Issue:
  - Writes the lowest-index non-busy entry, as sampled at the start of the cycle.
  - An entry freed by dispatch in the same cycle is not reusable until the next cycle.
- Issue bypass: if issue_qj_wait=1 and issue_qj matches a CDB tag valid this cycle, store that result and clear wj. The same rule applies to k.
- Wakeup:
  - Every busy entry with wj=1 and qj equal to a valid CDB tag captures the result and clears wj. The same rule applies to k.
  - Both CDBs are checked independently. If both match, the ALU CDB wins; equal tags are illegal anyway.
- Select: the lowest-index busy entry with wj=0 and wk=0, evaluated on state at the start of the cycle. Entries issued or woken this cycle are eligible next cycle at the earliest. Minimum issue-to-dispatch latency is therefore 1 cycle.
- Dispatch (registered):
  - On the edge, alu_valid<=1 and the alu_* fields are loaded from the selected entry, which becomes non-busy.
  - With no candidate, alu_valid<=0 and the alu_* fields hold their previous values.
- One dispatch per cycle; the ALU always accepts, so there is no backpressure.
- Issue, wakeup and dispatch may all occur in one cycle on distinct entries.
- Result latency seen by a dependent: producer dispatch edge N → ALU result on edge N+1 → dependent woken at edge N+2 → dependent dispatched at edge N+3.
- Wrap-around: tags are opaque; no ordering by ROB id. Selection is by index only.

Test Plan:
- Reset then issue add with rob 3, vj=5, vk=7, no waits → next edge alu_valid=1, alu_rob_id=3, alu_v1=5, alu_v2=7, alu_op=000; the following cycle alu_valid=0.
- Issue sub with qj=2 waiting, vk=1; two cycles later alu_cdb_ready with rob 2, result 10 → dispatch the cycle after with alu_v1=10, alu_v2=1, alu_op_other=1.
- Issue with qk=5 waiting in the same cycle that lsb_cdb_ready has rob 5, result 0xFFFF_FFFF → bypass captured; dispatch next edge with alu_v2=0xFFFF_FFFF.
- Issue 8 instructions that depend on an absent tag → full=1 after the 8th. Broadcast that tag → entries dispatch in index order 0..7, one per cycle; full drops the cycle after the first dispatch.
- Fill 3 waiting entries, assert flush in the same cycle as an issue → all entries empty, alu_valid=0, full=0. A later broadcast of the old tags causes no dispatch.
- Hold rdy=0 for 4 cycles with a ready entry and a CDB pulse → no dispatch and no wakeup. Release rdy → dispatch resumes with the pre-stall operand values.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ALU/branch instructions, snoops the
// ALU and LSB result buses to wake waiting operands, and dispatches at most one
// ready entry per cycle to the ALU through registered outputs.
module alu_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic [2:0]       issue_op,
    input  logic [6:0]       issue_instr_type,
    input  logic             issue_op_other,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_wait,
    input  logic             issue_qk_wait,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,
    output logic             full,
    output logic             alu_valid,
    output logic [ROB_W-1:0] alu_rob_id,
    output logic [2:0]       alu_op,
    output logic [6:0]       alu_instr_type,
    output logic             alu_op_other,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2,
    input  logic             alu_cdb_ready,
    input  logic [ROB_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]      alu_cdb_result,
    input  logic             lsb_cdb_ready,
    input  logic [ROB_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]      lsb_cdb_result
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0] busy_q;
    logic [RS_SIZE-1:0] wj_q;
    logic [RS_SIZE-1:0] wk_q;
    logic [RS_SIZE-1:0] other_q;
    logic [ROB_W-1:0]   rob_q  [RS_SIZE];
    logic [2:0]         op_q   [RS_SIZE];
    logic [6:0]         type_q [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [ROB_W-1:0]   qj_q   [RS_SIZE];
    logic [ROB_W-1:0]   qk_q   [RS_SIZE];

    // Registered dispatch port
    logic             alu_valid_q;
    logic [ROB_W-1:0] alu_rob_id_q;
    logic [2:0]       alu_op_q;
    logic [6:0]       alu_type_q;
    logic             alu_other_q;
    logic [31:0]      alu_v1_q;
    logic [31:0]      alu_v2_q;

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             free_found;
    logic [31:0]      iss_vj_d;
    logic [31:0]      iss_vk_d;
    logic             iss_wj_d;
    logic             iss_wk_d;

    assign full           = &busy_q;
    assign alu_valid      = alu_valid_q;
    assign alu_rob_id     = alu_rob_id_q;
    assign alu_op         = alu_op_q;
    assign alu_instr_type = alu_type_q;
    assign alu_op_other   = alu_other_q;
    assign alu_v1         = alu_v1_q;
    assign alu_v2         = alu_v2_q;

    // Lowest free entry for issue and lowest ready entry for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy_q[IDX_W'(i)] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy_q[IDX_W'(i)] && !wj_q[IDX_W'(i)] && !wk_q[IDX_W'(i)] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue-time bypass: an operand whose producer broadcasts this cycle is captured directly
    always_comb begin
        iss_vj_d = issue_vj;
        iss_wj_d = issue_qj_wait;
        iss_vk_d = issue_vk;
        iss_wk_d = issue_qk_wait;
        if (issue_qj_wait) begin
            if (alu_cdb_ready && alu_cdb_rob_id == issue_qj) begin
                iss_vj_d = alu_cdb_result;
                iss_wj_d = 1'b0;
            end else if (lsb_cdb_ready && lsb_cdb_rob_id == issue_qj) begin
                iss_vj_d = lsb_cdb_result;
                iss_wj_d = 1'b0;
            end
        end
        if (issue_qk_wait) begin
            if (alu_cdb_ready && alu_cdb_rob_id == issue_qk) begin
                iss_vk_d = alu_cdb_result;
                iss_wk_d = 1'b0;
            end else if (lsb_cdb_ready && lsb_cdb_rob_id == issue_qk) begin
                iss_vk_d = lsb_cdb_result;
                iss_wk_d = 1'b0;
            end
        end
    end

    // Entry state update: wakeup, dispatch and issue touch distinct entries
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            wj_q         <= '0;
            wk_q         <= '0;
            alu_valid_q  <= 1'b0;
            alu_rob_id_q <= '0;
            alu_op_q     <= '0;
            alu_type_q   <= '0;
            alu_other_q  <= 1'b0;
            alu_v1_q     <= '0;
            alu_v2_q     <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy_q      <= '0;
                alu_valid_q <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[IDX_W'(i)] && wj_q[IDX_W'(i)]) begin
                        if (alu_cdb_ready && alu_cdb_rob_id == qj_q[IDX_W'(i)]) begin
                            vj_q[IDX_W'(i)] <= alu_cdb_result;
                            wj_q[IDX_W'(i)] <= 1'b0;
                        end else if (lsb_cdb_ready && lsb_cdb_rob_id == qj_q[IDX_W'(i)]) begin
                            vj_q[IDX_W'(i)] <= lsb_cdb_result;
                            wj_q[IDX_W'(i)] <= 1'b0;
                        end
                    end
                    if (busy_q[IDX_W'(i)] && wk_q[IDX_W'(i)]) begin
                        if (alu_cdb_ready && alu_cdb_rob_id == qk_q[IDX_W'(i)]) begin
                            vk_q[IDX_W'(i)] <= alu_cdb_result;
                            wk_q[IDX_W'(i)] <= 1'b0;
                        end else if (lsb_cdb_ready && lsb_cdb_rob_id == qk_q[IDX_W'(i)]) begin
                            vk_q[IDX_W'(i)] <= lsb_cdb_result;
                            wk_q[IDX_W'(i)] <= 1'b0;
                        end
                    end
                end

                if (sel_found) begin
                    alu_valid_q       <= 1'b1;
                    alu_rob_id_q      <= rob_q[sel_idx];
                    alu_op_q          <= op_q[sel_idx];
                    alu_type_q        <= type_q[sel_idx];
                    alu_other_q       <= other_q[sel_idx];
                    alu_v1_q          <= vj_q[sel_idx];
                    alu_v2_q          <= vk_q[sel_idx];
                    busy_q[sel_idx]   <= 1'b0;
                end else begin
                    alu_valid_q <= 1'b0;
                end

                // free_found is false exactly when full, so a dropped issue changes nothing
                if (issue_valid && free_found) begin
                    busy_q[free_idx]  <= 1'b1;
                    rob_q[free_idx]   <= issue_rob_id;
                    op_q[free_idx]    <= issue_op;
                    type_q[free_idx]  <= issue_instr_type;
                    other_q[free_idx] <= issue_op_other;
                    vj_q[free_idx]    <= iss_vj_d;
                    vk_q[free_idx]    <= iss_vk_d;
                    wj_q[free_idx]    <= iss_wj_d;
                    wk_q[free_idx]    <= iss_wk_d;
                    qj_q[free_idx]    <= issue_qj;
                    qk_q[free_idx]    <= issue_qk;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: expected dispatches are queued when stimulus is driven
// and compared in order whenever the DUT raises alu_valid.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        issue_valid;
    logic [3:0]  issue_rob_id;
    logic [2:0]  issue_op;
    logic [6:0]  issue_instr_type;
    logic        issue_op_other;
    logic [31:0] issue_vj, issue_vk;
    logic        issue_qj_wait, issue_qk_wait;
    logic [3:0]  issue_qj, issue_qk;
    logic        full;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [2:0]  alu_op;
    logic [6:0]  alu_instr_type;
    logic        alu_op_other;
    logic [31:0] alu_v1, alu_v2;
    logic        alu_cdb_ready;
    logic [3:0]  alu_cdb_rob_id;
    logic [31:0] alu_cdb_result;
    logic        lsb_cdb_ready;
    logic [3:0]  lsb_cdb_rob_id;
    logic [31:0] lsb_cdb_result;

    typedef struct packed {
        logic [3:0]  rob;
        logic [2:0]  op;
        logic [6:0]  itype;
        logic        other;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   disp_cnt  = 0;
    int   cnt_snap;

    alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_rob_id(issue_rob_id), .issue_op(issue_op),
        .issue_instr_type(issue_instr_type), .issue_op_other(issue_op_other),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_wait(issue_qj_wait), .issue_qk_wait(issue_qk_wait),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .full(full), .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_op(alu_op),
        .alu_instr_type(alu_instr_type), .alu_op_other(alu_op_other),
        .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_result(alu_cdb_result),
        .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_result(lsb_cdb_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every dispatch must match the oldest expected entry
    always @(negedge clk) begin
        if (alu_valid === 1'b1) begin
            exp_t e;
            disp_cnt++;
            check("dispatch_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rob_id",    32'(alu_rob_id),     32'(e.rob));
                check("op",        32'(alu_op),         32'(e.op));
                check("instr_type",32'(alu_instr_type), 32'(e.itype));
                check("op_other",  32'(alu_op_other),   32'(e.other));
                check("v1",        alu_v1,              e.v1);
                check("v2",        alu_v2,              e.v2);
            end
        end
    end

    task automatic drive_issue(input logic [3:0] rob, input logic [2:0] op, input logic [6:0] itype,
                               input logic other, input logic [31:0] vj, input logic [31:0] vk,
                               input logic wj, input logic [3:0] qj, input logic wk, input logic [3:0] qk);
        issue_valid      = 1'b1;
        issue_rob_id     = rob;
        issue_op         = op;
        issue_instr_type = itype;
        issue_op_other   = other;
        issue_vj         = vj;
        issue_vk         = vk;
        issue_qj_wait    = wj;
        issue_qj         = qj;
        issue_qk_wait    = wk;
        issue_qk         = qk;
        @(negedge clk);
        issue_valid   = 1'b0;
        issue_qj_wait = 1'b0;
        issue_qk_wait = 1'b0;
    endtask

    task automatic alu_bcast(input logic [3:0] rob, input logic [31:0] res);
        alu_cdb_ready  = 1'b1;
        alu_cdb_rob_id = rob;
        alu_cdb_result = res;
        @(negedge clk);
        alu_cdb_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_rob_id = '0; issue_op = '0; issue_instr_type = '0;
        issue_op_other = 1'b0; issue_vj = '0; issue_vk = '0;
        issue_qj_wait = 1'b0; issue_qk_wait = 1'b0; issue_qj = '0; issue_qk = '0;
        alu_cdb_ready = 1'b0; alu_cdb_rob_id = '0; alu_cdb_result = '0;
        lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_result = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid",  32'(alu_valid), 32'd0);
        check("rst_full",   32'(full), 32'd0);
        check("rst_rob",    32'(alu_rob_id), 32'd0);
        check("rst_op",     32'(alu_op), 32'd0);
        check("rst_type",   32'(alu_instr_type), 32'd0);
        check("rst_other",  32'(alu_op_other), 32'd0);
        check("rst_v1",     alu_v1, 32'd0);
        check("rst_v2",     alu_v2, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ready add: one-cycle issue-to-dispatch, single-cycle strobe
        sb.push_back(exp_t'{4'd3, 3'd0, 7'h33, 1'b0, 32'd5, 32'd7});
        drive_issue(4'd3, 3'd0, 7'h33, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        check("add_not_yet", 32'(alu_valid), 32'd0);
        @(negedge clk);
        check("add_dispatch", 32'(alu_valid), 32'd1);
        @(negedge clk);
        check("add_strobe_drop", 32'(alu_valid), 32'd0);

        // Sub waiting on tag 2; both CDBs carry tag 2, ALU CDB wins
        sb.push_back(exp_t'{4'd4, 3'd0, 7'h33, 1'b1, 32'd10, 32'd1});
        drive_issue(4'd4, 3'd0, 7'h33, 1'b1, 32'd99, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
        @(negedge clk);
        check("sub_waiting", 32'(alu_valid), 32'd0);
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_result = 32'hDEAD;
        alu_bcast(4'd2, 32'd10);
        lsb_cdb_ready = 1'b0;
        check("sub_woken_not_disp", 32'(alu_valid), 32'd0);
        @(negedge clk);
        check("sub_dispatch", 32'(alu_valid), 32'd1);

        // Issue bypass from LSB CDB on k operand
        sb.push_back(exp_t'{4'd6, 3'd7, 7'h13, 1'b0, 32'h1234, 32'hFFFF_FFFF});
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd5; lsb_cdb_result = 32'hFFFF_FFFF;
        drive_issue(4'd6, 3'd7, 7'h13, 1'b0, 32'h1234, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5);
        lsb_cdb_ready = 1'b0;
        check("bypass_not_yet", 32'(alu_valid), 32'd0);
        @(negedge clk);
        check("bypass_dispatch", 32'(alu_valid), 32'd1);
        repeat (2) @(negedge clk);

        // Fill all 8 entries waiting on tag 9
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("full_before_8th", 32'(full), 32'd0);
            sb.push_back(exp_t'{4'(i), 3'd0, 7'h33, 1'b0, 32'hAB, 32'(100 + i)});
            drive_issue(4'(i), 3'd0, 7'h33, 1'b0, 32'd0, 32'(100 + i), 1'b1, 4'd9, 1'b0, 4'd0);
        end
        check("full_after_8th", 32'(full), 32'd1);
        // Issue while full is dropped; a ready rob 15 must never appear
        drive_issue(4'd15, 3'd0, 7'h33, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        check("full_drop_issue", 32'(full), 32'd1);
        alu_bcast(4'd9, 32'hAB);
        check("fill_woken_not_disp", 32'(alu_valid), 32'd0);
        check("fill_still_full", 32'(full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("drain_valid", 32'(alu_valid), 32'd1);
            if (k == 0) check("full_drop_after_first", 32'(full), 32'd0);
        end
        @(negedge clk);
        check("drain_done", 32'(alu_valid), 32'd0);

        // Flush: 3 waiting entries, plus a dispatch in flight, plus an issue in the flush cycle
        for (int i = 1; i <= 3; i++)
            drive_issue(4'(i), 3'd0, 7'h33, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd12);
        sb.push_back(exp_t'{4'd14, 3'd1, 7'h33, 1'b0, 32'd3, 32'd4});
        drive_issue(4'd14, 3'd1, 7'h33, 1'b0, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        check("pre_flush_valid", 32'(alu_valid), 32'd1);
        flush = 1'b1;
        drive_issue(4'd13, 3'd0, 7'h33, 1'b0, 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0);
        flush = 1'b0;
        check("flush_valid", 32'(alu_valid), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        cnt_snap = disp_cnt;
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd13; lsb_cdb_result = 32'd1;
        alu_bcast(4'd12, 32'd5);
        lsb_cdb_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_no_dispatch", 32'(disp_cnt), 32'(cnt_snap));

        // rdy stall: ready entry B and waiting entry A; CDB pulse during stall is ignored
        drive_issue(4'd1, 3'd2, 7'h13, 1'b0, 32'd0, 32'h77, 1'b1, 4'd8, 1'b0, 4'd0);
        sb.push_back(exp_t'{4'd2, 3'd4, 7'h33, 1'b0, 32'h55, 32'h66});
        drive_issue(4'd2, 3'd4, 7'h33, 1'b0, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0);
        rdy = 1'b0;
        cnt_snap = disp_cnt;
        alu_bcast(4'd8, 32'h99);
        check("stall_valid", 32'(alu_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(alu_valid), 32'd0);
        end
        check("stall_no_dispatch", 32'(disp_cnt), 32'(cnt_snap));
        rdy = 1'b1;
        @(negedge clk);
        check("resume_dispatch", 32'(alu_valid), 32'd1);
        @(negedge clk);
        check("stall_wakeup_ignored", 32'(alu_valid), 32'd0);
        sb.push_back(exp_t'{4'd1, 3'd2, 7'h13, 1'b0, 32'h42, 32'h77});
        alu_bcast(4'd8, 32'h42);
        check("a_woken_not_disp", 32'(alu_valid), 32'd0);
        @(negedge clk);
        check("a_dispatch", 32'(alu_valid), 32'd1);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
